memory_stage: RTL and testbench

- Pipeline MEM stage. Consumes the EX/MEM register outputs and performs the data-memory access over a valid/ready port.
- Store data is aligned onto byte lanes; load data is extracted and extended.
- Produces the registered MEM/WB outputs for writeback.
- While an access waits on memory, StallM is asserted so upstream holds EX/MEM stable.

---
 rtl/memory_stage_pkg.sv | 18 +
 rtl/memory_stage_load_align.sv | 21 ++
 rtl/memory_stage.sv | 105 ++++++++++
 tb/tb_memory_stage.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg: size encodings, FSM states and byte-lane helpers for the MEM stage.
package memory_stage_pkg;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;
  localparam logic [7:0] BE_B = 8'h01;
  localparam logic [7:0] BE_H = 8'h03;
  localparam logic [7:0] BE_W = 8'h0F;
  localparam logic [7:0] BE_D = 8'hFF;
  typedef enum logic {ST_IDLE, ST_BUSY} state_e;
  function automatic logic [7:0] be_mask(input logic [1:0] sz);
    return sz == SZ_B ? BE_B : sz == SZ_H ? BE_H : sz == SZ_W ? BE_W : BE_D;
  endfunction
  function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] off);
    return (sz >= SZ_H && off[0]) || (sz >= SZ_W && off[1:0] != 2'b00) || (sz == SZ_D && off != 3'b000);
  endfunction
endpackage

// File: rtl/memory_stage_load_align.sv
// load_align_unit: shifts a read doubleword down to the addressed byte and sign/zero extends it.
module load_align_unit
  import memory_stage_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [2:0]      off_i,
  input  logic [1:0]      size_i,
  input  logic            unsigned_i,
  output logic [XLEN-1:0] data_o
);
  logic [XLEN-1:0] s;
  always_comb begin
    s = rdata_i >> {off_i, 3'b000};
    data_o = size_i == SZ_B ? {{(XLEN-8){!unsigned_i && s[7]}}, s[7:0]}
           : size_i == SZ_H ? {{(XLEN-16){!unsigned_i && s[15]}}, s[15:0]}
           : size_i == SZ_W ? {{(XLEN-32){!unsigned_i && s[31]}}, s[31:0]}
           : s;
  end
endmodule

// File: rtl/memory_stage.sv
// memory_stage: pipeline MEM stage with valid/ready data-memory port, stall/timeout FSM and MEM/WB register.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteEnM,
  input  logic            MemtoRegM,
  input  logic            JALM,
  input  logic            MemReadEnM,
  input  logic            MemWriteEnM,
  input  logic [1:0]      MemSizeM,
  input  logic [1:0]      LoadSizeM,
  input  logic            LoadUnsignedM,
  input  logic [4:0]      RdM,
  input  logic [XLEN-1:0] PcPlus4M,
  input  logic [XLEN-1:0] ReadData2M,
  input  logic [XLEN-1:0] ALUResultM,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [7:0]      dmem_be,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            StallM,
  output logic            MisalignM,
  output logic            BusErrM,
  output logic            RegWriteEnW,
  output logic            MemtoRegW,
  output logic            JALW,
  output logic [4:0]      RdW,
  output logic [XLEN-1:0] ReadDataW,
  output logic [XLEN-1:0] ALUResultW,
  output logic [XLEN-1:0] PcPlus4W
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            op, busy, mis, timeout, done, bubble;
  logic [1:0]      sz;
  logic [2:0]      off;
  logic [XLEN-1:0] load_data;
  load_align_unit #(.XLEN(XLEN)) u_align (
    .rdata_i   (dmem_rdata),
    .off_i     (off),
    .size_i    (sz),
    .unsigned_i(LoadUnsignedM),
    .data_o    (load_data)
  );
  always_comb begin
    op         = MemReadEnM || MemWriteEnM;
    sz         = MemReadEnM ? LoadSizeM : MemSizeM;
    off        = ALUResultM[2:0];
    mis        = misaligned(sz, off);
    busy       = state_q == ST_BUSY;
    timeout    = busy && cnt_q == CW'(TIMEOUT_CYCLES);
    dmem_req   = !rst && (busy ? !timeout : op && !mis);
    dmem_we    = MemWriteEnM && !MemReadEnM;
    dmem_addr  = {ALUResultM[XLEN-1:3], 3'b000};
    dmem_wdata = ReadData2M << {off, 3'b000};
    dmem_be    = be_mask(sz) << off;
    StallM     = dmem_req && !dmem_ready;
    done       = dmem_req && dmem_ready;
    bubble     = timeout || (!busy && op && mis);
    state_d    = StallM ? ST_BUSY : ST_IDLE;
    cnt_d      = busy && StallM ? cnt_q + 1'b1 : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      MisalignM   <= 1'b0;
      BusErrM     <= 1'b0;
      RegWriteEnW <= 1'b0;
      MemtoRegW   <= 1'b0;
      JALW        <= 1'b0;
      RdW         <= '0;
      ReadDataW   <= '0;
      ALUResultW  <= '0;
      PcPlus4W    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      MisalignM <= !busy && op && mis;
      BusErrM   <= timeout;
      if (StallM) begin
        RegWriteEnW <= 1'b0;
        MemtoRegW   <= 1'b0;
        JALW        <= 1'b0;
      end else begin
        RegWriteEnW <= RegWriteEnM && RdM != 5'd0 && !bubble;
        MemtoRegW   <= MemtoRegM && !bubble;
        JALW        <= JALM && !bubble;
        RdW         <= RdM;
        ALUResultW  <= ALUResultM;
        PcPlus4W    <= PcPlus4M;
      end
      if (done && MemReadEnM) ReadDataW <= load_data;
    end
  end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed self-checking bench for the MEM stage.
module tb_memory_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteEnM, MemtoRegM, JALM, MemReadEnM, MemWriteEnM, LoadUnsignedM;
  logic [1:0]  MemSizeM, LoadSizeM;
  logic [4:0]  RdM, RdW;
  logic [63:0] PcPlus4M, ReadData2M, ALUResultM, dmem_addr, dmem_wdata, dmem_rdata;
  logic [63:0] ReadDataW, ALUResultW, PcPlus4W;
  logic        dmem_req, dmem_we, dmem_ready, StallM, MisalignM, BusErrM;
  logic        RegWriteEnW, MemtoRegW, JALW;
  logic [7:0]  dmem_be;
  int passed = 0, total = 0;

  memory_stage dut (
    .clk(clk), .rst(rst), .RegWriteEnM(RegWriteEnM), .MemtoRegM(MemtoRegM), .JALM(JALM),
    .MemReadEnM(MemReadEnM), .MemWriteEnM(MemWriteEnM), .MemSizeM(MemSizeM), .LoadSizeM(LoadSizeM),
    .LoadUnsignedM(LoadUnsignedM), .RdM(RdM), .PcPlus4M(PcPlus4M), .ReadData2M(ReadData2M),
    .ALUResultM(ALUResultM), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM), .RegWriteEnW(RegWriteEnW),
    .MemtoRegW(MemtoRegW), .JALW(JALW), .RdW(RdW), .ReadDataW(ReadDataW), .ALUResultW(ALUResultW),
    .PcPlus4W(PcPlus4W)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    RegWriteEnM = 0; MemtoRegM = 0; JALM = 0; MemReadEnM = 0; MemWriteEnM = 0;
    MemSizeM = 0; LoadSizeM = 0; LoadUnsignedM = 0; RdM = 0;
    PcPlus4M = 0; ReadData2M = 0; ALUResultM = 0; dmem_ready = 0; dmem_rdata = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    dmem_ready = 1;
    #1;
    total++; if (dmem_req !== 1'b0 || StallM !== 1'b0) $display("FAIL reset_req: got req=%b stall=%b expected 0 0", dmem_req, StallM); else passed++;
    total++; if ({RegWriteEnW, MemtoRegW, JALW, MisalignM, BusErrM} !== 5'b0) $display("FAIL reset_ctrl: got %b expected 00000", {RegWriteEnW, MemtoRegW, JALW, MisalignM, BusErrM}); else passed++;
    total++; if (ReadDataW !== 64'h0 || ALUResultW !== 64'h0 || PcPlus4W !== 64'h0 || RdW !== 5'd0) $display("FAIL reset_data: got rd=%h alu=%h pc=%h rdw=%0d expected zeros", ReadDataW, ALUResultW, PcPlus4W, RdW); else passed++;
    tick();
    total++; if (StallM !== 1'b0 || dmem_req !== 1'b0) $display("FAIL idle_ready_ignored: got req=%b stall=%b expected 0 0", dmem_req, StallM); else passed++;
    dmem_ready = 0;
  endtask

  task automatic test_store();
    clear_inputs();
    MemWriteEnM = 1; MemSizeM = 2'b11; ALUResultM = 64'h1000; ReadData2M = 64'h1122334455667788;
    PcPlus4M = 64'h404; dmem_ready = 1;
    #1;
    total++; if (dmem_req !== 1 || dmem_we !== 1 || dmem_be !== 8'hFF || StallM !== 0) $display("FAIL sd_port: got req=%b we=%b be=%h stall=%b expected 1 1 ff 0", dmem_req, dmem_we, dmem_be, StallM); else passed++;
    total++; if (dmem_wdata !== 64'h1122334455667788 || dmem_addr !== 64'h1000) $display("FAIL sd_data: got wdata=%h addr=%h expected 1122334455667788 1000", dmem_wdata, dmem_addr); else passed++;
    tick();
    total++; if (RegWriteEnW !== 0 || ALUResultW !== 64'h1000 || PcPlus4W !== 64'h404) $display("FAIL sd_wb: got rwe=%b alu=%h pc=%h expected 0 1000 404", RegWriteEnW, ALUResultW, PcPlus4W); else passed++;
    MemSizeM = 2'b00; ALUResultM = 64'h1005; ReadData2M = 64'hAB;
    #1;
    total++; if (dmem_be !== 8'h20 || dmem_wdata !== 64'h0000AB0000000000 || dmem_addr !== 64'h1000) $display("FAIL sb_lane: got be=%h wdata=%h addr=%h expected 20 0000ab0000000000 1000", dmem_be, dmem_wdata, dmem_addr); else passed++;
    MemSizeM = 2'b10; ALUResultM = 64'h1004; ReadData2M = 64'hDEADBEEF;
    #1;
    total++; if (dmem_be !== 8'hF0 || dmem_wdata !== 64'hDEADBEEF00000000) $display("FAIL sw_lane: got be=%h wdata=%h expected f0 deadbeef00000000", dmem_be, dmem_wdata); else passed++;
    tick();
    clear_inputs();
  endtask

  task automatic test_load_byte();
    clear_inputs();
    MemReadEnM = 1; MemWriteEnM = 1; LoadSizeM = 2'b00; MemSizeM = 2'b11; ALUResultM = 64'h1003;
    RegWriteEnM = 1; MemtoRegM = 1; RdM = 5'd5; dmem_rdata = 64'h0000000080000000; dmem_ready = 1;
    #1;
    total++; if (dmem_we !== 0 || dmem_be !== 8'h08 || StallM !== 0) $display("FAIL lb_port: got we=%b be=%h stall=%b expected 0 08 0", dmem_we, dmem_be, StallM); else passed++;
    tick();
    total++; if (ReadDataW !== 64'hFFFFFFFFFFFFFF80) $display("FAIL lb_signed: got %h expected ffffffffffffff80", ReadDataW); else passed++;
    total++; if (RegWriteEnW !== 1 || MemtoRegW !== 1 || RdW !== 5'd5) $display("FAIL lb_wb: got rwe=%b m2r=%b rd=%0d expected 1 1 5", RegWriteEnW, MemtoRegW, RdW); else passed++;
    LoadUnsignedM = 1; RdM = 5'd0;
    tick();
    total++; if (ReadDataW !== 64'h80) $display("FAIL lbu_zero: got %h expected 0000000000000080", ReadDataW); else passed++;
    total++; if (RegWriteEnW !== 0) $display("FAIL rd0_no_write: got %b expected 0", RegWriteEnW); else passed++;
    clear_inputs();
    tick();
  endtask

  task automatic test_wait_states();
    int n = 0;
    clear_inputs();
    MemReadEnM = 1; LoadSizeM = 2'b10; ALUResultM = 64'h2004; RegWriteEnM = 1; MemtoRegM = 1; JALM = 1;
    RdM = 5'd9; dmem_rdata = 64'h87654321_00000000;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (StallM === 1'b1 && dmem_req === 1'b1 && dmem_addr === 64'h2000) n++;
      tick();
    end
    total++; if (n !== 3) $display("FAIL lw_stall_cycles: got %0d expected 3", n); else passed++;
    total++; if (RegWriteEnW !== 0 || JALW !== 0) $display("FAIL lw_stall_bubble: got rwe=%b jal=%b expected 0 0", RegWriteEnW, JALW); else passed++;
    dmem_ready = 1;
    #1;
    total++; if (StallM !== 0 || dmem_req !== 1) $display("FAIL lw_release: got stall=%b req=%b expected 0 1", StallM, dmem_req); else passed++;
    tick();
    total++; if (RegWriteEnW !== 1 || ReadDataW !== 64'hFFFFFFFF87654321 || JALW !== 1) $display("FAIL lw_result: got rwe=%b data=%h jal=%b expected 1 ffffffff87654321 1", RegWriteEnW, ReadDataW, JALW); else passed++;
    clear_inputs();
    tick();
  endtask

  task automatic test_misalign();
    clear_inputs();
    MemWriteEnM = 1; MemSizeM = 2'b01; ALUResultM = 64'h1001; RegWriteEnM = 1; RdM = 5'd3; dmem_ready = 1;
    #1;
    total++; if (dmem_req !== 0 || StallM !== 0) $display("FAIL sh_mis_noreq: got req=%b stall=%b expected 0 0", dmem_req, StallM); else passed++;
    tick();
    clear_inputs();
    #1;
    total++; if (MisalignM !== 1 || RegWriteEnW !== 0) $display("FAIL sh_mis_pulse: got mis=%b rwe=%b expected 1 0", MisalignM, RegWriteEnW); else passed++;
    tick();
    total++; if (MisalignM !== 0) $display("FAIL sh_mis_single: got %b expected 0", MisalignM); else passed++;
  endtask

  task automatic test_timeout();
    int n = 0;
    clear_inputs();
    MemReadEnM = 1; LoadSizeM = 2'b11; ALUResultM = 64'h3000; RegWriteEnM = 1; RdM = 5'd7;
    #1;
    while (dmem_req === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    total++; if (n !== 17) $display("FAIL to_req_cycles: got %0d expected 17", n); else passed++;
    total++; if (StallM !== 0) $display("FAIL to_stall_release: got %b expected 0", StallM); else passed++;
    tick();
    clear_inputs();
    #1;
    total++; if (BusErrM !== 1 || RegWriteEnW !== 0) $display("FAIL to_buserr: got err=%b rwe=%b expected 1 0", BusErrM, RegWriteEnW); else passed++;
    tick();
    total++; if (BusErrM !== 0) $display("FAIL to_buserr_single: got %b expected 0", BusErrM); else passed++;
  endtask

  task automatic test_reset_busy();
    clear_inputs();
    MemReadEnM = 1; LoadSizeM = 2'b11; ALUResultM = 64'h4000; PcPlus4M = 64'h88; RdM = 5'd4; RegWriteEnM = 1;
    dmem_rdata = 64'h5; dmem_ready = 1;
    tick();
    dmem_ready = 0; ALUResultM = 64'h4008;
    tick(); tick();
    total++; if (StallM !== 1 || ALUResultW !== 64'h4000) $display("FAIL rstb_pre: got stall=%b alu=%h expected 1 4000", StallM, ALUResultW); else passed++;
    rst = 1;
    tick();
    total++; if (dmem_req !== 0 || StallM !== 0) $display("FAIL rstb_req: got req=%b stall=%b expected 0 0", dmem_req, StallM); else passed++;
    total++; if ({RegWriteEnW, MemtoRegW, JALW, RdW} !== 8'h0 || ReadDataW !== 0 || ALUResultW !== 0 || PcPlus4W !== 0) $display("FAIL rstb_wb: got ctrl=%h rd=%h alu=%h pc=%h expected zeros", {RegWriteEnW, MemtoRegW, JALW, RdW}, ReadDataW, ALUResultW, PcPlus4W); else passed++;
    clear_inputs();
    rst = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_store();
    test_load_byte();
    test_wait_states();
    test_misalign();
    test_timeout();
    test_reset_busy();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
